// File: rtl/div_unit.sv
// ============================================================================
//  Module      : div_unit
//  Description : Multi-cycle radix-2 restoring divider for DIV/DIVU.
//                Returns {remainder, quotient} and stalls EX until done.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  annul,
    input  logic                  signed_div,
    input  logic [DATA_W-1:0]     opdata1,
    input  logic [DATA_W-1:0]     opdata2,
    output logic [2*DATA_W-1:0]   result,
    output logic                  ready,
    output logic                  stall_req
);

    localparam int              c_CNT_W  = $clog2(DATA_W + 1);
    localparam logic [1:0]      c_S_IDLE   = 2'd0;
    localparam logic [1:0]      c_S_BYZERO = 2'd1;
    localparam logic [1:0]      c_S_BUSY   = 2'd2;
    localparam logic [1:0]      c_S_DONE   = 2'd3;
    localparam logic [DATA_W-1:0] c_ONE    = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_W);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic [1:0]          r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [DATA_W:0]     r_rem;
    logic [DATA_W-1:0]   r_quo;
    logic [DATA_W-1:0]   r_divisor;
    logic                r_signed;
    logic                r_sign1;
    logic                r_sign2;

    logic [DATA_W-1:0]   w_abs1;
    logic [DATA_W-1:0]   w_abs2;
    logic [DATA_W:0]     w_rem_sh;
    logic [DATA_W:0]     w_diff;
    logic [DATA_W-1:0]   w_quo_fix;
    logic [DATA_W-1:0]   w_rem_fix;

    // Signed operands are reduced to magnitudes at acceptance; signs are restored at the end.
    assign w_abs1 = (signed_div && opdata1[DATA_W-1]) ? (~opdata1 + c_ONE) : opdata1;
    assign w_abs2 = (signed_div && opdata2[DATA_W-1]) ? (~opdata2 + c_ONE) : opdata2;

    // The shifted remainder is below 2*divisor, so DATA_W+1 bits hold it; the top bit of the difference is the borrow.
    assign w_rem_sh = {r_rem[DATA_W-1:0], r_quo[DATA_W-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_divisor};

    assign w_quo_fix = (r_signed && (r_sign1 ^ r_sign2)) ? (~r_quo + c_ONE) : r_quo;
    assign w_rem_fix = (r_signed && r_sign1) ? (~r_rem[DATA_W-1:0] + c_ONE) : r_rem[DATA_W-1:0];

    assign stall_req = start & ~ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= c_S_IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_signed  <= 1'b0;
            r_sign1   <= 1'b0;
            r_sign2   <= 1'b0;
            result    <= '0;
            ready     <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    ready <= 1'b0;
                    if (start && !annul) begin
                        r_divisor <= w_abs2;
                        r_quo     <= w_abs1;
                        r_rem     <= '0;
                        r_cnt     <= '0;
                        r_signed  <= signed_div;
                        r_sign1   <= opdata1[DATA_W-1];
                        r_sign2   <= opdata2[DATA_W-1];
                        r_state   <= (opdata2 == '0) ? c_S_BYZERO : c_S_BUSY;
                    end
                end

                c_S_BYZERO: begin
                    if (annul) begin
                        r_state <= c_S_IDLE;
                        ready   <= 1'b0;
                    end else begin
                        result  <= '0;
                        ready   <= 1'b1;
                        r_state <= c_S_DONE;
                    end
                end

                c_S_BUSY: begin
                    if (annul) begin
                        r_state <= c_S_IDLE;
                        ready   <= 1'b0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        result  <= {w_rem_fix, w_quo_fix};
                        ready   <= 1'b1;
                        r_state <= c_S_DONE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                        if (!w_diff[DATA_W]) begin
                            r_rem <= w_diff;
                            r_quo <= {r_quo[DATA_W-2:0], 1'b1};
                        end else begin
                            r_rem <= w_rem_sh;
                            r_quo <= {r_quo[DATA_W-2:0], 1'b0};
                        end
                    end
                end

                c_S_DONE: begin
                    // Holding start keeps the result presented; a new divide needs start to drop first.
                    if (annul || !start) begin
                        r_state <= c_S_IDLE;
                        ready   <= 1'b0;
                    end
                end

                default: begin
                    r_state <= c_S_IDLE;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
//  Module      : tb_div_unit
//  Description : Scoreboard bench for div_unit with a plain-arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_unit;

    localparam int DATA_W = 32;

    logic                clk;
    logic                resetn;
    logic                start;
    logic                annul;
    logic                signed_div;
    logic [DATA_W-1:0]   opdata1;
    logic [DATA_W-1:0]   opdata2;
    logic [2*DATA_W-1:0] result;
    logic                ready;
    logic                stall_req;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] exp_q[$];
    logic        prev_ready = 1'b0;

    div_unit #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .annul      (annul),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .result     (result),
        .ready      (ready),
        .stall_req  (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: integer division in 64-bit arithmetic; divide-by-zero yields 0.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    // Monitor: each rising ready pops one expected result.
    always @(negedge clk) begin
        if (!resetn) begin
            prev_ready = 1'b0;
        end else begin
            if (ready && !prev_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", 64'd1, 64'd0);
                end else begin
                    check("scoreboard_result", result, exp_q.pop_front());
                end
            end
            prev_ready = ready;
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn, input int hold);
        logic [63:0] exp;
        int          n;
        int          exp_lat;
        logic        stall_ok;
        @(posedge clk); #1;
        opdata1    = a;
        opdata2    = b;
        signed_div = sgn;
        start      = 1'b1;
        exp        = model(a, b, sgn);
        exp_q.push_back(exp);
        exp_lat    = (b == 32'd0) ? 2 : DATA_W + 2;
        @(posedge clk); #1;
        opdata1    = $urandom;
        opdata2    = $urandom;
        signed_div = ~sgn;
        n          = 1;
        stall_ok   = 1'b1;
        while (!ready && n < 100) begin
            if (stall_req !== 1'b1) stall_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        check("latency", 64'(n), 64'(exp_lat));
        check("stall_while_busy", {63'd0, stall_ok}, 64'd1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("done_hold_ready", {63'd0, ready}, 64'd1);
            check("done_hold_result", result, exp);
        end
        start = 1'b0;
        @(posedge clk); #1;
        check("idle_ready_low", {63'd0, ready}, 64'd0);
        check("idle_result_kept", result, exp);
    endtask

    task automatic begin_and_wait(input logic [31:0] a, input logic [31:0] b, input logic sgn, input int edges);
        @(posedge clk); #1;
        opdata1    = a;
        opdata2    = b;
        signed_div = sgn;
        start      = 1'b1;
        @(posedge clk); #1;
        repeat (edges) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        logic        s, saw;
        resetn = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
        opdata1 = '0; opdata2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {63'd0, ready}, 64'd0);
        check("reset_result", result, 64'd0);
        check("reset_stall", {63'd0, stall_req}, 64'd0);
        resetn = 1'b1;

        run_op(32'd100, 32'd7, 1'b0, 3);
        check("divu_100_7", result, {32'd2, 32'd14});
        run_op(32'hFFFF_FFF9, 32'h2, 1'b1, 0);
        check("div_m7_2", result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0);
        check("div_7_m2", result, {32'h0000_0001, 32'hFFFF_FFFD});
        run_op(32'd12345, 32'd0, 1'b0, 1);
        run_op(32'h8000_0001, 32'd0, 1'b1, 0);
        check("div_by_zero", result, 64'd0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        check("div_intmin_m1", result, {32'h0, 32'h8000_0000});
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        check("divu_intmin_ffff", result, {32'h8000_0000, 32'h0});

        // Annul on the 10th busy edge.
        begin_and_wait(32'd999, 32'd3, 1'b0, 9);
        annul = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; annul = 1'b0;
        check("annul_ready_low", {63'd0, ready}, 64'd0);
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready) saw = 1'b1;
        end
        check("annul_no_ready", {63'd0, saw}, 64'd0);
        run_op(32'hFFFF_FFFF, 32'h10, 1'b0, 0);
        check("divu_after_annul", result, {32'hF, 32'h0FFF_FFFF});

        // Synchronous reset mid-divide.
        begin_and_wait(32'd5000, 32'd7, 1'b1, 15);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("midreset_ready", {63'd0, ready}, 64'd0);
        check("midreset_result", result, 64'd0);
        start = 1'b0; resetn = 1'b1;
        @(posedge clk); #1;
        check("midreset_idle_ready", {63'd0, ready}, 64'd0);

        run_op(32'd81, 32'd9, 1'b0, 0);
        run_op(32'hFFFF_FF9C, 32'd9, 1'b1, 0);

        for (int k = 0; k < 30; k++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = $urandom;
                1: b = $urandom_range(1, 20);
                2: b = 32'd0;
                3: b = 32'hFFFF_FFFF - $urandom_range(0, 15);
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            s = 1'($urandom_range(0, 1));
            run_op(a, b, s, $urandom_range(0, 2));
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
